d_ip_timer_mc: RTL

Second-generation register-programmable timer/counter. It is parametrised in counter width and comparator count, and adds a prescaler, TOP-limited, up/down and one-shot modes, plus per-channel PWM outputs. It sits on the same byte-wide module bus (6-bit addr, 8-bit data, wr_en/mod_en) as the first-generation timer. It drives level interrupts to the system interrupt controller.

---
 rtl/d_ip_timer_mc.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/d_ip_timer_mc.sv
// d_ip_timer_mc: byte-bus programmable timer/counter with prescaler,
// TOP-limited, up/down and one-shot modes, N_CMP compare channels with
// level interrupts and registered PWM outputs.
// Optional capture unit (CAP register at 0x0C, STAT/INT_EN bit 7) is
// built only when the macro TIMER_CAPTURE_EN is defined.
module d_ip_timer_mc #(
    parameter int CNT_W   = 16,
    parameter int N_CMP   = 2,
    parameter int PRESC_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       addr,
    input  logic             wr_en,
    input  logic             mod_en,
    input  logic [7:0]       wdata,
    output logic [7:0]       rdata,
    input  logic             timer_in,
    output logic             overflow_int,
    output logic [N_CMP-1:0] comp_match_int,
    output logic [N_CMP-1:0] timer_out
);
    localparam int NB     = CNT_W / 8;
    localparam int SH_W   = (CNT_W > 8) ? CNT_W - 8 : 1;
    localparam int PCNT_W = 1 << PRESC_W;
    localparam logic [7:0] BASE_MASK = 8'((9'd1 << (N_CMP + 1)) - 9'd1);
`ifdef TIMER_CAPTURE_EN
    localparam logic [7:0] STAT_MASK = BASE_MASK | 8'h80;
`else
    localparam logic [7:0] STAT_MASK = BASE_MASK;
`endif
    localparam logic [1:0] MODE_TOP  = 2'b01;
    localparam logic [1:0] MODE_UPDN = 2'b10;
    localparam logic [1:0] MODE_ONE  = 2'b11;

    logic              en, clksel, out_en, dir_down;
    logic [1:0]        mode;
    logic [PRESC_W-1:0] presc;
    logic [7:0]        int_en, stat, stat_set, rd_byte;
    logic [CNT_W-1:0]  cnt, top, cnt_next;
    logic [CNT_W-1:0]  cmp [N_CMP];
    logic [SH_W-1:0]   shadow;
    logic [PCNT_W-1:0] presc_cnt, presc_lim;
    logic              sync1, sync2, sync3, ext_edge;
    logic              wr, rd, wr_ctrl, wr_presc, wr_inten, wr_stat, wr_cnt;
    logic              tick, dir_next, ovf_set, oneshot_stop, cap_set;

    assign wr       = mod_en & wr_en;
    assign rd       = mod_en & ~wr_en;
    assign wr_ctrl  = wr && (addr == 6'h00);
    assign wr_presc = wr && (addr == 6'h01);
    assign wr_inten = wr && (addr == 6'h02);
    assign wr_stat  = wr && (addr == 6'h03);
    assign wr_cnt   = wr && (addr >= 6'h04) && (addr < 6'(4 + NB));

    // A tick is suppressed when the CPU writes CNT in the same cycle
    assign ext_edge  = sync2 & ~sync3;
    assign presc_lim = ~({PCNT_W{1'b1}} << presc);
    assign tick      = en & ~wr_cnt & (clksel ? ext_edge : (presc_cnt == presc_lim));

    // Two-flop synchroniser for timer_in plus an edge-detect flop
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= timer_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // Prescaler: free-runs only while enabled on the internal clock source
    always_ff @(posedge clk) begin
        if (rst || !en || clksel || wr_presc || wr_cnt || (presc_cnt == presc_lim))
            presc_cnt <= '0;
        else
            presc_cnt <= presc_cnt + PCNT_W'(1);
    end

    // Counter next value, direction and overflow for the current mode
    always_comb begin
        cnt_next     = cnt + CNT_W'(1);
        dir_next     = dir_down;
        ovf_set      = &cnt;
        oneshot_stop = 1'b0;
        case (mode)
            MODE_TOP, MODE_ONE: begin
                if (cnt == top) begin
                    cnt_next     = '0;
                    ovf_set      = 1'b1;
                    oneshot_stop = (mode == MODE_ONE);
                end
            end
            MODE_UPDN: begin
                if (dir_down) begin
                    ovf_set  = (cnt == CNT_W'(1));
                    cnt_next = (cnt == '0) ? '0 : cnt - CNT_W'(1);
                    if (cnt <= CNT_W'(1))
                        dir_next = 1'b0;
                end else if (cnt == top) begin
                    ovf_set  = 1'b0;
                    dir_next = 1'b1;
                    cnt_next = (cnt == '0) ? '0 : cnt - CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Status set events: overflow, compare hits on tick loads, capture
    always_comb begin
        stat_set    = 8'h00;
        stat_set[0] = tick & ovf_set;
        for (int i = 0; i < N_CMP; i++)
            stat_set[1 + i] = tick && (cnt_next == cmp[i]);
        stat_set[7] = cap_set;
    end

    // Programmer-visible registers; CPU writes override tick updates
    always_ff @(posedge clk) begin
        if (rst) begin
            en       <= 1'b0;
            clksel   <= 1'b0;
            mode     <= 2'b00;
            out_en   <= 1'b0;
            presc    <= '0;
            int_en   <= 8'h00;
            stat     <= 8'h00;
            cnt      <= '0;
            top      <= '1;
            dir_down <= 1'b0;
            for (int i = 0; i < N_CMP; i++)
                cmp[i] <= '0;
        end else begin
            if (wr_ctrl)
                {out_en, mode, clksel, en} <= wdata[4:0];
            else if (tick && oneshot_stop)
                en <= 1'b0;
            if (wr_presc)
                presc <= wdata[PRESC_W-1:0];
            if (wr_inten)
                int_en <= wdata & STAT_MASK;
            stat <= ((stat & ~(wr_stat ? wdata : 8'h00)) | stat_set) & STAT_MASK;
            if (tick) begin
                cnt      <= cnt_next;
                dir_down <= dir_next;
            end
            if (wr_cnt)
                dir_down <= 1'b0;
            for (int b = 0; b < NB; b++) begin
                if (wr && (addr == 6'(4 + b)))
                    cnt[8*b +: 8] <= wdata;
                if (wr && (addr == 6'(8 + b)))
                    top[8*b +: 8] <= wdata;
            end
            for (int i = 0; i < N_CMP; i++)
                for (int b = 0; b < NB; b++)
                    if (wr && (addr == 6'(16 + 4*i + b)))
                        cmp[i][8*b +: 8] <= wdata;
        end
    end

`ifdef TIMER_CAPTURE_EN
    logic [CNT_W-1:0] cap;
    assign cap_set = en & ~clksel & ext_edge;

    // Capture holds the pre-increment CNT at a synchronised timer_in edge
    always_ff @(posedge clk) begin
        if (rst)
            cap <= '0;
        else if (cap_set)
            cap <= cnt;
    end
`else
    assign cap_set = 1'b0;
`endif

    // Read-data mux; upper CNT bytes come from the byte-0 snapshot
    always_comb begin
        rd_byte = 8'h00;
        if (addr == 6'h00) rd_byte = {3'b000, out_en, mode, clksel, en};
        if (addr == 6'h01) rd_byte = 8'(presc);
        if (addr == 6'h02) rd_byte = int_en;
        if (addr == 6'h03) rd_byte = stat;
        if (addr == 6'h04) rd_byte = cnt[7:0];
        for (int b = 1; b < NB; b++)
            if (addr == 6'(4 + b)) rd_byte = shadow[8*(b-1) +: 8];
        for (int b = 0; b < NB; b++) begin
            if (addr == 6'(8 + b)) rd_byte = top[8*b +: 8];
`ifdef TIMER_CAPTURE_EN
            if (addr == 6'(12 + b)) rd_byte = cap[8*b +: 8];
`endif
        end
        for (int i = 0; i < N_CMP; i++)
            for (int b = 0; b < NB; b++)
                if (addr == 6'(16 + 4*i + b)) rd_byte = cmp[i][8*b +: 8];
    end

    // Registered read port and CNT snapshot on a byte-0 read
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata  <= 8'h00;
            shadow <= '0;
        end else if (rd) begin
            rdata <= rd_byte;
            if (addr == 6'h04)
                shadow <= SH_W'(cnt >> 8);
        end
    end

    // PWM outputs, high while CNT is below the channel compare value
    always_ff @(posedge clk) begin
        if (rst)
            timer_out <= '0;
        else
            for (int i = 0; i < N_CMP; i++)
                timer_out[i] <= out_en & (cnt < cmp[i]);
    end

    assign overflow_int   = (stat[0] & int_en[0]) | (stat[7] & int_en[7]);
    assign comp_match_int = stat[N_CMP:1] & int_en[N_CMP:1];

endmodule
